uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_DIV, default 5208: sclk cycles per bit period; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: 1 or 2.
REQ-005 sclk  in  1  system clock; only clock in the block, all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rx  in  1  asynchronous serial line, idle high.
REQ-008 rx_data  out  DATA_BITS  received word, LSB = first bit on the line.
REQ-009 rx_valid  out  1  rx_data and error flags hold a word.
REQ-010 rx_ready  in  1  consumer accepts the word when rx_valid and rx_ready are both high in the same cycle.
REQ-011 frame_err  out  1  held word had a stop bit sampled low; qualified by rx_valid.
REQ-012 parity_err  out  1  held word failed the parity check; qualified by rx_valid; always 0 when PARITY = 0.
REQ-013 overrun_err  out  1  one-cycle pulse when a completed frame is dropped.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 rx passes through a 2-flop synchronizer plus one history flop; a start condition is history = 1 and synchronized = 0.
REQ-016 Baud counter: width $clog2(CLK_DIV); counts 0..CLK_DIV-1, then wraps to 0; held at 0 in IDLE; restarts at 0 on a start condition.
REQ-017 Each bit is decided by a 2-of-3 majority vote of synchronized rx sampled at counts MID-1, MID and MID+1, where MID = CLK_DIV/2 - 1; the decision is taken at count MID+1.
REQ-018 FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
REQ-019 IDLE -> START on a start condition.
REQ-020 START: a majority of 1 is a false start and the FSM returns to IDLE with no output; a majority of 0 goes to DATA at counter wrap.
REQ-021 DATA: shifts in DATA_BITS bits, LSB first; bit counter runs 0..DATA_BITS-1; at the last bit it goes to PAR if PARITY != 0, else to STOP.
REQ-022 PAR: parity_err = (XOR of data bits XOR parity bit) != (PARITY == 1).
REQ-023 STOP: STOP_BITS stop bits are sampled; any low stop bit sets frame_err for the word.
REQ-024 End of frame is the decision point of the last stop bit. The word is delivered there, and the FSM goes to IDLE if that bit was high, else to WAIT_IDLE.
REQ-025 WAIT_IDLE (break or line fault) returns to IDLE only after synchronized rx is high; no new start condition is accepted before that.
REQ-026 Output register, delivery latency: rx_valid rises exactly one sclk after the end-of-frame decision cycle.
REQ-027 Load rule: the word loads if rx_valid = 0, or if rx_valid = 1 and rx_ready = 1 in that same cycle (back-to-back delivery, rx_valid stays high).
REQ-028 Overrun: if rx_valid = 1 and rx_ready = 0 at end of frame, the new frame is discarded, held data and flags are unchanged, and overrun_err pulses for one cycle.
REQ-029 rx_valid falls the cycle after the handshake unless a new word loads in that cycle; rx_data and the flags are stable while rx_valid is high.
REQ-030 Words with frame_err or parity_err are still delivered.

Reset
REQ-031 When rst is high at a sclk edge: FSM = IDLE, counters = 0, synchronizer and history flops = 1, rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0, busy = 0.
REQ-032 Reset mid-frame abandons the frame with no output; reception resumes on the next start condition after reset is released.

Verification
REQ-033 CLK_DIV=16, 8N1, send 0xA5, hold rx_ready=0 -> rx_valid=1 one cycle after the stop-bit decision, rx_data=0xA5, frame_err=0, parity_err=0.
REQ-034 PARITY=2, send 0x07 with parity bit 0 -> word 0x07 delivered with parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-035 Send 0x3C with stop bit low and rx held low for 3 bit periods -> frame_err=1, busy=1 until rx returns high, no second word.
REQ-036 rx low pulse of 4 sclk cycles -> busy=1, then false start detected, back to IDLE, rx_valid stays 0.
REQ-037 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun_err one-cycle pulse; then rx_ready=1 -> rx_valid falls next cycle.
REQ-038 Assert rst during DATA of 0x55, then send 0x66 -> only 0x66 delivered.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted bit sampling, optional parity,
// 1 or 2 stop bits, and a single-entry valid/ready output holding register.
module uart_rx_cfg #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int MID   = CLK_DIV / 2 - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(MID + 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  state_t               state;
  logic                 sync1, sync2, hist;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_cnt;
  logic                 vote_a, vote_b;
  logic [DATA_BITS-1:0] shift;
  logic                 ferr_acc, perr_acc;

  logic start_cond, vote, decide, wrap, eof, frame_bad, par_bad;

  assign start_cond = hist & ~sync2;
  assign vote       = (vote_a & vote_b) | (vote_a & sync2) | (vote_b & sync2);
  assign decide     = (cnt == SAMP_C);
  assign wrap       = (cnt == CNT_LAST);
  assign eof        = (state == STOP) && decide && (bit_cnt == LAST_STOP);
  assign frame_bad  = ferr_acc | ~vote;
  assign par_bad    = ((^shift) ^ vote) != (PARITY == 1);
  assign busy       = (state != IDLE);

  // Synchronizer and history flops reset high so an idle line never looks like a start.
  always_ff @(posedge sclk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      vote_a   <= 1'b0;
      vote_b   <= 1'b0;
      shift    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else begin
      if (state == IDLE || state == WAIT_IDLE) cnt <= '0;
      else if (wrap)                           cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
      if (cnt == SAMP_A) vote_a <= sync2;
      if (cnt == SAMP_B) vote_b <= sync2;

      case (state)
        IDLE: begin
          if (start_cond) begin
            state    <= START;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
          end
        end
        START: begin
          if (decide && vote) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (decide) shift <= {vote, shift[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (decide) perr_acc <= par_bad;
          if (wrap)   state    <= STOP;
        end
        STOP: begin
          if (decide) ferr_acc <= frame_bad;
          // A low final stop bit may be a break; wait for the line to recover.
          if (eof) begin
            state <= vote ? IDLE : WAIT_IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        WAIT_IDLE: begin
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: a frame finishing while the slot is full and not being drained is dropped.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (eof) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift;
          frame_err  <= frame_bad;
          parity_err <= perr_acc;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
